// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use hazard controller for a
// 5-stage pipeline. Tracks the destination of each in-flight instruction in
// EX/MEM/WB slots, registers per-source forwarding selects for the
// instruction entering EX, and stalls ID on load-use hazards.
//
// Optional feature macro: FWD_WB_BYPASS_EN
//   defined   -> a hit on the WB slot selects 2'b11 (read-before-write regfile)
//   undefined -> a WB hit selects 2'b00 (write-first regfile covers it)
//
// FSM states:
//   state    | meaning
//   ST_RUN   | pipeline advancing normally, no load-use hold
//   ST_STALL | previous cycle held ID and injected a bubble into EX
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_mem_read_i,
  input  logic                      id_flush_i,
  input  logic                      mem_freeze_i,
  output logic                      stall_o,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic [15:0]               stall_count_o
);

  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_MEM_WB = 2'b01;
  localparam logic [1:0] SEL_EX_MEM = 2'b10;
`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] SEL_WB     = 2'b11;
`else
  localparam logic [1:0] SEL_WB     = 2'b00;
`endif

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } slot_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  slot_t                s0_q, s0_d;
  slot_t                s1_q, s1_d;
  slot_t                s2_q, s2_d;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
  logic [15:0]          stall_count_q, stall_count_d;
  state_t               state_q, state_d;

  logic [NUM_SRC-1:0]   hit_s0, hit_s1, hit_s2;
  logic                 load_hazard;
  logic                 bubble;

  // A slot only produces a forward when it really writes a non-zero register
  function automatic logic slot_hit(input slot_t s,
                                    input logic [REG_AW-1:0] src,
                                    input logic used);
    return used && s.valid && s.reg_write && (s.rd == src) && (s.rd != '0);
  endfunction

  // Per-source slot hits and load-use detection; a load in slot k is still
  // unavailable while k is below the configured load latency
  always_comb begin
    hit_s0      = '0;
    hit_s1      = '0;
    hit_s2      = '0;
    load_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_s0[i] = slot_hit(s0_q, id_src_i[i*REG_AW +: REG_AW], id_src_used_i[i]);
      hit_s1[i] = slot_hit(s1_q, id_src_i[i*REG_AW +: REG_AW], id_src_used_i[i]);
      hit_s2[i] = slot_hit(s2_q, id_src_i[i*REG_AW +: REG_AW], id_src_used_i[i]);
      if (hit_s0[i] && s0_q.is_load) begin
        load_hazard = 1'b1;
      end
      if ((LOAD_STALL > 1) && hit_s1[i] && s1_q.is_load) begin
        load_hazard = 1'b1;
      end
      if ((LOAD_STALL > 2) && hit_s2[i] && s2_q.is_load) begin
        load_hazard = 1'b1;
      end
    end
  end

  // Flush kills the hazard outright; a frozen pipeline never stalls on top
  always_comb begin
    stall_o = load_hazard && !id_flush_i && !mem_freeze_i;
    bubble  = stall_o || id_flush_i;
  end

  // Slot shift on advance; EX receives a bubble on stall or flush
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (!mem_freeze_i) begin
      s2_d = s1_q;
      s1_d = s0_q;
      if (bubble) begin
        s0_d = '0;
      end else begin
        s0_d.valid     = 1'b1;
        s0_d.rd        = id_rd_i;
        s0_d.reg_write = id_reg_write_i;
        s0_d.is_load   = id_mem_read_i;
      end
    end
  end

  // Forwarding selects for the instruction entering EX; youngest hit wins
  always_comb begin
    fwd_sel_d = fwd_sel_q;
    if (!mem_freeze_i) begin
      fwd_sel_d = '0;
      if (!bubble) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (hit_s0[i]) begin
            fwd_sel_d[2*i +: 2] = SEL_EX_MEM;
          end else if (hit_s1[i]) begin
            fwd_sel_d[2*i +: 2] = SEL_MEM_WB;
          end else if (hit_s2[i]) begin
            fwd_sel_d[2*i +: 2] = SEL_WB;
          end else begin
            fwd_sel_d[2*i +: 2] = SEL_RF;
          end
        end
      end
    end
  end

  // Observation FSM: follows stall, frozen together with the pipeline
  always_comb begin
    state_d = state_q;
    if (!mem_freeze_i) begin
      case (state_q)
        ST_RUN:   if (stall_o)  state_d = ST_STALL;
        ST_STALL: if (!stall_o) state_d = ST_RUN;
        default:                state_d = ST_RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_o && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      fwd_sel_q     <= '0;
      stall_count_q <= '0;
      state_q       <= ST_RUN;
    end else begin
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      fwd_sel_q     <= fwd_sel_d;
      stall_count_q <= stall_count_d;
      state_q       <= state_d;
    end
  end

  assign fwd_sel_o     = fwd_sel_q;
  assign stall_count_o = stall_count_q;

  // The observation state must always mirror the previous unfrozen cycle's stall
  a_state_tracks_stall: assert property (
    @(posedge clk) disable iff (!rst_n)
      !mem_freeze_i |=> (!rst_n || ((state_q == ST_STALL) == $past(stall_o)))
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int LS      = 1;
`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] WB_EXP = 2'b11;
`else
  localparam logic [1:0] WB_EXP = 2'b00;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_SRC*REG_AW-1:0] id_src = '0;
  logic [NUM_SRC-1:0]        id_src_used = '0;
  logic [REG_AW-1:0]         id_rd = '0;
  logic                      id_reg_write = 1'b0;
  logic                      id_mem_read = 1'b0;
  logic                      id_flush = 1'b0;
  logic                      mem_freeze = 1'b0;
  logic                      stall;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic [15:0]               stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LOAD_STALL(LS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_src_i      (id_src),
    .id_src_used_i (id_src_used),
    .id_rd_i       (id_rd),
    .id_reg_write_i(id_reg_write),
    .id_mem_read_i (id_mem_read),
    .id_flush_i    (id_flush),
    .mem_freeze_i  (mem_freeze),
    .stall_o       (stall),
    .fwd_sel_o     (fwd_sel),
    .stall_count_o (stall_count)
  );

  // ---------------- reference model (instruction-level view) --------------
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } ins_t;

  ins_t     pipe [3];   // index = age in stages past ID: 0=EX, 1=MEM, 2=WB
  bit [1:0] msel [NUM_SRC];
  int       mcnt;

  function automatic bit produces(input ins_t x, input bit [4:0] r);
    return x.v && x.rw && (r != 0) && (x.rd == r);
  endfunction

  function automatic bit m_stall();
    bit haz = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (id_src_used[i])
        for (int k = 0; k < LS; k++)
          if (produces(pipe[k], id_src[i*REG_AW +: REG_AW]) && pipe[k].ld) haz = 1;
    return haz && !id_flush && !mem_freeze;
  endfunction

  function automatic bit [1:0] m_select(input int i);
    bit [1:0] by_age [3];
    by_age[0] = 2'b10;
    by_age[1] = 2'b01;
    by_age[2] = WB_EXP;
    if (!id_src_used[i]) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (produces(pipe[k], id_src[i*REG_AW +: REG_AW])) return by_age[k];
    return 2'b00;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{v:0, rd:0, rw:0, ld:0};
    for (int i = 0; i < NUM_SRC; i++) msel[i] = 2'b00;
    mcnt = 0;
  endtask

  task automatic m_clock();
    bit s, b;
    if (mem_freeze) return;
    s = m_stall();
    b = s || id_flush;
    for (int i = 0; i < NUM_SRC; i++) msel[i] = b ? 2'b00 : m_select(i);
    if (s && mcnt < 65535) mcnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (b) pipe[0] = '{v:0, rd:0, rw:0, ld:0};
    else   pipe[0] = '{v:1, rd:id_rd, rw:id_reg_write, ld:id_mem_read};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [1:0] used,
                       input logic [4:0] rd, input logic rw, input logic ld);
    id_src       = {b, a};
    id_src_used  = used;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = ld;
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    id_flush   = 1'b0;
    mem_freeze = 1'b0;
    issue(0, 0, 2'b00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=0000", fwd_sel); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
  endtask

  task automatic test_alu_hazard();
    apply_reset();
    issue(0, 0, 2'b00, 5, 1, 0); tick();
    issue(5, 0, 2'b01, 6, 1, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    checks++; if (fwd_sel !== 4'b0010) begin failures++; $display("FAIL alu_fwd got=%b exp=0010", fwd_sel); end
  endtask

  task automatic test_two_back();
    apply_reset();
    issue(0, 0, 2'b00, 7, 1, 0); tick();
    issue(1, 2, 2'b11, 3, 1, 0); tick();
    issue(0, 7, 2'b10, 8, 1, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL two_back_stall got=%b exp=0", stall); end
    tick();
    checks++; if (fwd_sel !== 4'b0100) begin failures++; $display("FAIL two_back_fwd got=%b exp=0100", fwd_sel); end
    issue(0, 0, 2'b00, 4, 1, 0); tick();
    issue(0, 0, 2'b00, 4, 1, 0); tick();
    issue(4, 4, 2'b11, 9, 1, 0); tick();
    checks++; if (fwd_sel !== 4'b1010) begin failures++; $display("FAIL priority_fwd got=%b exp=1010", fwd_sel); end
  endtask

  task automatic test_load_use();
    logic [1:0] exp_after;
    exp_after = (LS == 1) ? 2'b01 : WB_EXP;
    apply_reset();
    issue(0, 0, 2'b00, 9, 1, 1); tick();
    issue(9, 0, 2'b01, 10, 1, 0);
    for (int c = 0; c < LS; c++) begin
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_stall cyc=%0d got=%b exp=1", c, stall); end
      tick();
      checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL load_bubble_fwd cyc=%0d got=%b exp=0000", c, fwd_sel); end
    end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_release got=%b exp=0", stall); end
    checks++; if (stall_count !== 16'(LS)) begin failures++; $display("FAIL load_count got=%0d exp=%0d", stall_count, LS); end
    tick();
    checks++; if (fwd_sel[1:0] !== exp_after) begin failures++; $display("FAIL load_fwd got=%b exp=%b", fwd_sel[1:0], exp_after); end
    checks++; if (stall_count !== 16'(LS)) begin failures++; $display("FAIL load_count_hold got=%0d exp=%0d", stall_count, LS); end
  endtask

  task automatic test_r0_unused();
    apply_reset();
    issue(0, 0, 2'b00, 0, 1, 1); tick();
    issue(0, 0, 2'b11, 3, 1, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", stall); end
    tick();
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL r0_fwd got=%b exp=0000", fwd_sel); end
    issue(0, 0, 2'b00, 12, 1, 1); tick();
    issue(12, 12, 2'b00, 3, 1, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL unused_stall got=%b exp=0", stall); end
    tick();
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL unused_fwd got=%b exp=0000", fwd_sel); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL unused_count got=%0d exp=0", stall_count); end
  endtask

  task automatic test_flush_freeze();
    apply_reset();
    // flush beats a load-use hazard and the flushed r11 writer never reaches EX
    issue(0, 0, 2'b00, 9, 1, 1); tick();
    id_flush = 1'b1;
    issue(9, 0, 2'b01, 11, 1, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    id_flush = 1'b0;
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL flush_fwd got=%b exp=0000", fwd_sel); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", stall_count); end
    issue(11, 0, 2'b01, 0, 0, 0); tick();
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL flush_bubble got=%b exp=0000", fwd_sel); end
    // freeze holds slots and selects
    issue(0, 0, 2'b00, 5, 1, 0); tick();
    issue(5, 0, 2'b01, 6, 1, 0); tick();
    checks++; if (fwd_sel !== 4'b0010) begin failures++; $display("FAIL prefreeze_fwd got=%b exp=0010", fwd_sel); end
    mem_freeze = 1'b1;
    issue(6, 5, 2'b11, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL freeze_stall cyc=%0d got=%b exp=0", c, stall); end
      tick();
      checks++; if (fwd_sel !== 4'b0010) begin failures++; $display("FAIL freeze_fwd cyc=%0d got=%b exp=0010", c, fwd_sel); end
    end
    mem_freeze = 1'b0;
    #1;
    tick();
    checks++; if (fwd_sel !== 4'b0110) begin failures++; $display("FAIL postfreeze_fwd got=%b exp=0110", fwd_sel); end
    // freeze masks a load-use stall and does not count it
    issue(0, 0, 2'b00, 13, 1, 1); tick();
    mem_freeze = 1'b1;
    issue(13, 0, 2'b01, 14, 1, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL freeze_load_stall got=%b exp=0", stall); end
    tick();
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL freeze_load_count got=%0d exp=0", stall_count); end
    mem_freeze = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL unfreeze_stall got=%b exp=1", stall); end
    tick();
    checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL unfreeze_count got=%0d exp=1", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    issue(0, 0, 2'b00, 9, 1, 1); tick();
    issue(9, 0, 2'b01, 10, 1, 0);
    tick();
    issue(9, 0, 2'b01, 13, 1, 1); tick();
    checks++; if (fwd_sel !== 4'b0001) begin failures++; $display("FAIL midrst_pre_fwd got=%b exp=0001", fwd_sel); end
    issue(13, 0, 2'b01, 14, 1, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL midrst_pre_stall got=%b exp=1", stall); end
    checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=1", stall_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", stall); end
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL midrst_fwd got=%b exp=0000", fwd_sel); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", stall_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL postrst_stall got=%b exp=0", stall); end
    tick();
    checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL postrst_fwd got=%b exp=0000", fwd_sel); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL postrst_count got=%0d exp=0", stall_count); end
  endtask

  task automatic test_random();
    logic [2*NUM_SRC-1:0] exp_sel;
    bit                   exp_stall;
    apply_reset();
    m_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_SRC; i++) id_src[i*REG_AW +: REG_AW] = 5'($urandom_range(0, 3));
      id_src_used  = NUM_SRC'($urandom);
      id_rd        = 5'($urandom_range(0, 3));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_flush     = ($urandom_range(0, 7) == 0);
      mem_freeze   = ($urandom_range(0, 7) == 0);
      #1;
      exp_stall = m_stall();
      checks++; if (stall !== exp_stall) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, exp_stall); end
      @(posedge clk);
      m_clock();
      #1;
      for (int i = 0; i < NUM_SRC; i++) exp_sel[2*i +: 2] = msel[i];
      checks++; if (fwd_sel !== exp_sel) begin failures++; $display("FAIL rand_fwd n=%0d got=%b exp=%b", n, fwd_sel, exp_sel); end
      checks++; if (stall_count !== 16'(mcnt)) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, stall_count, mcnt); end
    end
    id_flush   = 1'b0;
    mem_freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_hazard();
    test_two_back();
    test_load_use();
    test_r0_unused();
    test_flush_freeze();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the 5-stage MIPS pipeline; successor to the two-operand ForwardUnit. It sits beside the ID/EX boundary and tracks the destination register of every in-flight instruction in internal EX, MEM and WB slots. It emits registered per-source forwarding selects for the instruction entering EX, and generates load-use stalls for a configurable load latency. It also honours branch flush and global memory freeze.

## Interface
- REG_AW, 5: register address width.
- NUM_SRC, 2: source operands per instruction (2..4); source i uses bits [i*REG_AW +: REG_AW].
- LOAD_STALL, 1: stages a load result trails an ALU result (1..2).
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_src  in  NUM_SRC*REG_AW  source register numbers of instruction in ID.
- id_src_used  in  NUM_SRC  per-source "operand actually read" flag.
- id_rd  in  REG_AW  destination register of instruction in ID.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_mem_read  in  1  ID instruction is a load.
- id_flush  in  1  kill ID instruction (taken branch/jump).
- mem_freeze  in  1  data memory busy; whole pipeline holds.
- stall  out  1  hold PC and IF/ID, insert bubble into EX (combinational).
- fwd_sel  out  2*NUM_SRC  registered forwarding select per source for instruction in EX.
- stall_count  out  16  saturating count of load-use stall cycles.

## Operation
- Slots s0 (EX), s1 (MEM), s2 (WB), each {valid, rd, reg_write, is_load}.
- A source i "hits" slot k when id_src_used[i], slot valid, reg_write, rd == source, rd != 0.
- Load-use: stall = 1 when any source hits slot k with is_load and k < LOAD_STALL, and id_flush = 0 and mem_freeze = 0.
- FSM states RUN, STALL. RUN→STALL when stall asserts; STALL→RUN on first cycle stall deasserts. State is for observation/coverage only; stall is always recomputed from the slots.
- Advance (mem_freeze = 0): s2 <= s1, s1 <= s0. s0 receives one of two values:
  - a bubble (valid = 0) when stall or id_flush is asserted;
  - otherwise the ID instruction {1, id_rd, id_reg_write, id_mem_read}.
- fwd_sel per source is loaded on advance. It is forced to 00 when a bubble is inserted. Otherwise the youngest hit wins:
  - hit s0 → 2'b10 (EX/MEM);
  - else hit s1 → 2'b01 (MEM/WB);
  - else hit s2 → 2'b11 only with the macro, otherwise 2'b00;
  - else 2'b00 (register file).
- A load hit that causes a stall never produces a select; the select is computed on the cycle the instruction finally advances.
- mem_freeze = 1: slots, fwd_sel, FSM state and stall_count hold; stall = 0.
- Simultaneous id_flush and hazard: the flush wins, and no stall is counted.
- stall_count increments on each stall cycle and saturates at 16'hFFFF.

## Timing
- Reset: all slots invalid, fwd_sel = 0, state RUN, stall_count = 0, stall = 0.
- Reset is honoured mid-stall; the first cycle after release is RUN with no stall.
- stall is combinational from ID inputs and slots in the same cycle.
- fwd_sel is valid the cycle after the ID→EX advance, for the full EX residency of that instruction.
- LOAD_STALL = 1: a dependent instruction immediately behind a load costs 1 stall cycle.
- LOAD_STALL = 2: the same case costs 2 stall cycles; with one independent instruction in between, the cost is 1 cycle.
- Without the macro, the register file must be write-first, so no s2 forward is needed.

## Configuration
- FWD_WB_BYPASS_EN defined: a hit on s2 yields 2'b11, selecting the WB-stage result. This is for a register file that is read-before-write.
- FWD_WB_BYPASS_EN undefined: select 2'b11 is never produced, and an s2 hit yields 2'b00.

## Test plan
- ALU hazard: the instruction writing r5 advances, then an instruction reading r5 as src0 advances. Required: fwd_sel[1:0] = 10, no stall.
- Two-back hazard: r7 is written, one unrelated instruction follows, then r7 is read on src1. Required: fwd_sel[3:2] = 01, and the EX/MEM select takes priority when the same register is written in both s0 and s1.
- Load-use: a load to r9 advances, then an instruction reading r9. Required: stall = 1 for LOAD_STALL cycles, a bubble in EX, stall_count = LOAD_STALL, then select 01.
- r0 and unused operands: id_src = 0, or id_src_used = 0 with a matching rd. Required: fwd_sel = 00, no stall.
- Flush and freeze: id_flush in the same cycle as a load-use hazard → stall = 0 and a bubble enters EX. mem_freeze held 3 cycles → slots and fwd_sel unchanged. rst_n pulsed low mid-stall → all outputs return to 0.
